// File: rtl/mem_responder.sv
// mem_responder: unified RAM plus an MMIO window (output FIFO, status, cycle counter) for the multicycle MIPS core.
// Define MEM_RESPONDER_CYCCNT_EN to build the cycle counter; otherwise CYCCNT reads 0 and writes are dropped.
module mem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fifo_full
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] OUTDATA_A  = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_A   = 32'hFFFF_FFF4;
  localparam logic [31:0] CYCCNT_A   = 32'hFFFF_FFF8;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic ovf, empty, in_ram, wr_en, push_req, push, pop, ovf_set, ovf_clr;
  logic [AW-1:0] idx;
  logic [31:0] status, cyc;

  assign in_ram    = adr < RAM_BYTES;
  assign idx       = adr[AW+1:2];
  assign wr_en     = memwrite & ~reset;
  assign empty     = count == '0;
  assign fifo_full = count == CW'(FIFO_DEPTH);
  assign out_valid = ~empty;
  assign out_data  = empty ? 32'h0 : fifo[rd_ptr];
  assign pop       = out_valid & out_ready & ~reset;
  assign push_req  = wr_en & (adr == OUTDATA_A);
  assign push      = push_req & (~fifo_full | pop);
  // A rejected push leaves the FIFO untouched and only flags overflow.
  assign ovf_set   = push_req & fifo_full & ~pop;
  assign ovf_clr   = wr_en & (adr == STATUS_A) & writedata[2];
  assign status    = {16'h0, 8'(count), 5'h0, ovf, fifo_full, empty};

  always_comb
    readdata = in_ram              ? ram[idx] :
               (adr == OUTDATA_A)  ? out_data :
               (adr == STATUS_A)   ? status   :
               (adr == CYCCNT_A)   ? cyc      : 32'h0;

  always_ff @(posedge clk)
    if (wr_en && in_ram) ram[idx] <= writedata;

  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      ovf   <= ovf_set | (ovf & ~ovf_clr);
    end
  end

`ifdef MEM_RESPONDER_CYCCNT_EN
  always_ff @(posedge clk)
    cyc <= reset ? 32'h0 : (wr_en && adr == CYCCNT_A) ? writedata : cyc + 32'h1;
`else
  assign cyc = 32'h0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench with a scoreboard queue for FIFO output order.
module tb_mem_responder;
  localparam logic [31:0] OUTDATA_A = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_A  = 32'hFFFF_FFF4;
  localparam logic [31:0] CYCCNT_A  = 32'hFFFF_FFF8;

  logic clk = 0, reset = 1, memwrite = 0, out_ready = 0;
  logic [31:0] adr = 0, writedata = 0;
  logic [31:0] readdata, out_data;
  logic out_valid, fifo_full;
  logic [31:0] sb[$];
  int tests = 0, fails = 0;

  mem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memwrite(memwrite),
    .readdata(readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a;
    writedata = d;
    memwrite = 1;
    tick();
    memwrite = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic push(input logic [31:0] d);
    sb.push_back(d);
    wr(OUTDATA_A, d);
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    out_ready = 1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'h1);
      chk("drain_data", out_data, sb.pop_front());
      tick();
    end
    out_ready = 0;
    #1;
    chk("drain_empty", 32'(out_valid), 32'h0);
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_full", 32'(fifo_full), 32'h0);
    rd("rst_status", STATUS_A, 32'h1);
    rd("rst_outdata", OUTDATA_A, 32'h0);

    wr(32'h10, 32'hDEADBEEF);
    rd("ram_10", 32'h10, 32'hDEADBEEF);
    rd("ram_13", 32'h13, 32'hDEADBEEF);
    wr(32'h0, 32'h0BAD_F00D);
    wr(32'hFC, 32'h1234_5678);
    wr(32'h100, 32'hFFFF_0000);
    rd("ram_fc", 32'hFC, 32'h1234_5678);
    rd("ram_0_noalias", 32'h0, 32'h0BAD_F00D);
    rd("unmapped_100", 32'h100, 32'h0);
    rd("unmapped_ffc", 32'hFFFF_FFFC, 32'h0);

    for (int i = 1; i <= 4; i++) push(32'(i));
    chk("full_flag", 32'(fifo_full), 32'h1);
    rd("status_full", STATUS_A, 32'h0000_0402);
    rd("outdata_head", OUTDATA_A, 32'h1);
    wr(OUTDATA_A, 32'h5);
    rd("status_ovf", STATUS_A, 32'h0000_0406);
    chk("ovf_head_stable", out_data, 32'h1);
    wr(STATUS_A, 32'h4);
    rd("status_ovf_clr", STATUS_A, 32'h0000_0402);
    drain();

    push(32'h6);
    push(32'h7);
    push(32'h8);
    push(32'hA);
    adr = OUTDATA_A;
    writedata = 32'h9;
    memwrite = 1;
    out_ready = 1;
    #1;
    chk("pp_head", out_data, sb.pop_front());
    sb.push_back(32'h9);
    tick();
    memwrite = 0;
    out_ready = 0;
    rd("pp_status", STATUS_A, 32'h0000_0402);
    chk("pp_next_head", out_data, 32'h7);
    drain();

`ifdef MEM_RESPONDER_CYCCNT_EN
    wr(CYCCNT_A, 32'hFFFF_FFFE);
    rd("cyc_load", CYCCNT_A, 32'hFFFF_FFFE);
    tick();
    rd("cyc_inc", CYCCNT_A, 32'hFFFF_FFFF);
    tick();
    rd("cyc_wrap", CYCCNT_A, 32'h0);
`else
    wr(CYCCNT_A, 32'h0000_0123);
    rd("cyc_absent", CYCCNT_A, 32'h0);
`endif

    push(32'hB);
    push(32'hC);
    push(32'hD);
    rd("pre_rst_status", STATUS_A, 32'h0000_0300);
    reset = 1;
    adr = OUTDATA_A;
    writedata = 32'h99;
    memwrite = 1;
    out_ready = 1;
    tick();
    reset = 0;
    memwrite = 0;
    out_ready = 0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_full", 32'(fifo_full), 32'h0);
    rd("mid_rst_status", STATUS_A, 32'h0000_0001);
    rd("mid_rst_ram", 32'h10, 32'hDEADBEEF);
    tick();
    chk("mid_rst_nopush", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
